// File: rtl/freq_pkg.sv
// Shared constants and encodings for the three-phase frequency front end.
package freq_pkg;

  localparam int DIV_W = 24;
  localparam logic [DIV_W-1:0] NUM_CONST = 24'd800000;

  typedef enum logic [1:0] {
    PH_A = 2'd0,
    PH_B = 2'd1,
    PH_C = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Round-robin successor, A -> B -> C -> A.
  function automatic phase_t phase_next(input phase_t p);
    case (p)
      PH_A:    return PH_B;
      PH_B:    return PH_C;
      default: return PH_A;
    endcase
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative restoring divider producing one quotient bit per clock.
module seq_divider
  import freq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] num,
  input  logic [DIV_W-1:0] den,
  output logic [DIV_W-1:0] quo,
  output logic             done
);

  localparam int IW = $clog2(DIV_W + 1);

  // Handshake: start is a one-cycle request that loads num/den on its edge;
  // DIV_W edges later done pulses for one cycle and quo holds until the next start.
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] den_r;
  logic [IW-1:0]    iter;
  logic             running;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   trial;

  always_comb begin
    shifted = {rem, quo[DIV_W-1]};
    trial   = shifted - {1'b0, den_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      den_r   <= '0;
      iter    <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= '0;
        quo     <= num;
        den_r   <= den;
        iter    <= IW'(DIV_W);
        running <= 1'b1;
      end else if (running) begin
        // A set MSB means the trial subtraction borrowed: restore.
        if (!trial[DIV_W]) begin
          rem <= trial[DIV_W-1:0];
          quo <= {quo[DIV_W-2:0], 1'b1};
        end else begin
          rem <= shifted[DIV_W-1:0];
          quo <= {quo[DIV_W-2:0], 1'b0};
        end
        iter <= iter - 1'b1;
        if (iter == IW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq3_div_scheduler.sv
// Per-phase half-period counters sharing one divider through a round-robin scheduler.
module freq3_div_scheduler
  import freq_pkg::*;
#(
  parameter int M  = 14,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [M-1:0] Vin_a,
  input  logic signed [M-1:0] Vin_b,
  input  logic signed [M-1:0] Vin_c,
  input  logic signed [M-1:0] offset,
  input  logic [7:0]          k,
  output logic [15:0]         freq_a,
  output logic [15:0]         freq_b,
  output logic [15:0]         freq_c,
  output logic [2:0]          freq_vld,
  output logic [2:0]          ovr,
  output logic                busy,
  output state_t              dbg_state
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic signed [M-1:0] vin [3];
  logic [CW-1:0]       cnt [3];
  logic [CW-1:0]       pend_cnt [3];
  logic [2:0]          pend;
  logic [2:0]          above;
  logic [2:0]          capture;
  logic [2:0]          gnt_vec;
  logic [15:0]         freq_r [3];

  state_t     state_q, state_d;
  phase_t     rr_ptr, cur, gnt_idx, cand;
  logic       gnt_found;
  logic       start;
  logic       wb;
  logic [DIV_W-1:0] den;
  logic [DIV_W-1:0] quo;
  logic             div_done;
  logic             unused_quo_hi;

  assign vin[0] = Vin_a;
  assign vin[1] = Vin_b;
  assign vin[2] = Vin_c;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      above[i]   = (vin[i] >= offset);
      capture[i] = !above[i] && (cnt[i] != '0);
    end
  end

  // A capture that lands on its own grant edge keeps pend set and is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i]      <= '0;
        pend_cnt[i] <= '0;
      end
      pend <= '0;
      ovr  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (above[i]) begin
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
        end else begin
          cnt[i] <= '0;
        end
        if (capture[i]) begin
          pend_cnt[i] <= cnt[i];
          pend[i]     <= 1'b1;
          if (pend[i] && !gnt_vec[i]) ovr[i] <= 1'b1;
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = PH_A;
    cand      = rr_ptr;
    for (int off = 0; off < 3; off++) begin
      if (!gnt_found && pend[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = phase_next(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wb      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          start   = 1'b1;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_WB;
      end
      ST_WB: begin
        wb      = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_vec = start ? (3'b001 << gnt_idx) : 3'b000;

  // k is only looked at here, so later changes cannot disturb a running division.
  always_comb begin
    den = (DIV_W'(pend_cnt[gnt_idx]) * DIV_W'(k)) << 1;
    if (den == '0) den = DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= PH_A;
      cur      <= PH_A;
      freq_vld <= '0;
      for (int i = 0; i < 3; i++) freq_r[i] <= '0;
    end else begin
      freq_vld <= '0;
      if (start) begin
        cur    <= gnt_idx;
        rr_ptr <= phase_next(gnt_idx);
      end
      if (wb) begin
        freq_r[cur] <= quo[15:0];
        freq_vld    <= 3'b001 << cur;
      end
    end
  end

  seq_divider u_div (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .num   (NUM_CONST),
    .den   (den),
    .quo   (quo),
    .done  (div_done)
  );

  assign unused_quo_hi = ^quo[DIV_W-1:16];

  assign freq_a    = freq_r[0];
  assign freq_b    = freq_r[1];
  assign freq_c    = freq_r[2];
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/freq3_div_scheduler.md
# freq3_div_scheduler

Three-phase frequency measurement front end for the sequence decomposer. Measures the positive half-period of each phase (A, B, C) in clock cycles and shares one iterative 24-bit divider between the three phases through a round-robin scheduler. Produces a registered 16-bit frequency word per phase, using the team's existing convention freq = 800000 / (2·count·k). Feeds the decomposer's per-phase frequency inputs.

## Interface
- M, 14, sample width of Vin_* and offset (signed)
- CW, 16, half-period counter width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- Vin_a, Vin_b, Vin_c  in  M (signed)  phase samples
- offset  in  M (signed)  zero-crossing threshold, shared
- k  in  8  scale factor, sampled at grant
- freq_a, freq_b, freq_c  out  16  latest frequency per phase
- freq_vld  out  3  one-cycle strobe, bit i = phase i updated (bit0 = A)
- ovr  out  3  sticky overrun per phase, cleared only by rst
- busy  out  1  divider in use

## Operation
- Per phase i, every cycle:
  - Vin_i >= offset: cnt_i += 1, saturating at 2^CW−1.
  - Vin_i < offset and cnt_i != 0: latch cnt_i into pend_cnt_i, set pend_i, clear cnt_i.
  - Capture while pend_i already set: overwrite pend_cnt_i (latest wins), set ovr_i.
- Scheduler FSM, states IDLE, DIV, WB:
  - IDLE: if any pend_i, grant the first set phase at or after rr_ptr (order A→B→C→A). On grant: clear pend_i, compute den, start the divider, go to DIV, set rr_ptr = granted+1 mod 3.
  - DIV: wait for divider done (24 iterations), then go to WB.
  - WB: write quotient[15:0] to freq_i, pulse freq_vld[i], go to IDLE.
- den = (2·pend_cnt_i·k) truncated to 24 bits; den == 0 is forced to 1. Numerator is the constant 800000 (24 bits).
- If a capture and a grant hit the same phase in the same cycle: the grant uses the old pend_cnt_i, the new value is stored, and pend_i stays set. No ovr is raised.
- busy = (state != IDLE).

## Timing
- Reset values: cnt_i = 0, pend_i = 0, freq_* = 0, freq_vld = 0, ovr = 0, busy = 0, rr_ptr = A, FSM = IDLE, divider idle.
- The capture edge sets pend_i. A grant can occur on the next edge.
- Grant edge G, then divider iterations on G+1..G+24, WB at G+25.
- freq_i and freq_vld[i] update on edge G+26, and the FSM is back in IDLE.
- The earliest next grant is edge G+27. Worst case from capture to update with all three phases pending is 3×27 cycles.
- k is sampled only at the grant edge. Changing k during DIV does not affect the result in progress.
- rst asserted mid-division aborts it immediately. No freq_vld pulse and no freq write occur.

## Structure
- Shared package freq_pkg holds:
  - NUM_CONST = 800000
  - DIV_W = 24
  - phase encoding A = 0, B = 1, C = 2
  - FSM state encoding
- Sub-module seq_divider (reused elsewhere):
  - Restoring divider, DIV_W-bit unsigned.
  - Ports: clk, rst, start, num, den, quo, done.
  - One quotient bit per cycle. done is a one-cycle pulse after DIV_W iterations.
- The top level holds the three counter/pending slices, the round-robin arbiter and the FSM.

## Test plan
- Phase A only, k = 4, 100 cycles above offset then below → den 800 → freq_a = 1000. freq_vld = 001 exactly 27 cycles after the capture edge. freq_b and freq_c stay 0.
- All three phases capture in the same cycle (cnt 100/50/1000, k = 8 → den 1600/800/16000):
  - Grant order A, B, C.
  - freq_a = 500, freq_b = 1000, freq_c = 50.
  - The three strobes are spaced 27 cycles apart.
- k = 0 with cnt = 10 → den forced to 1 → freq = 800000[15:0] = 13568.
- Phase B captures twice (counts 200 then 300) while the divider is busy on A:
  - ovr = 010.
  - freq_b = 800000/(600·k), using the latest count.
  - ovr stays set until rst.
- rst pulsed at G+10 of a division:
  - All outputs return to 0 and no strobe appears.
  - After release, a new measurement completes normally.
- Counter saturation: Vin_c held above offset for 70000 cycles with k = 1 → cnt_c = 65535 → den 131070 → freq_c = 6.
